// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF layer.
package lif_pkg;

  // Default membrane potential width and its container type
  localparam int unsigned POT_W = 8;
  typedef logic [POT_W-1:0] pot_t;

  // Default fixed-point scaling: an active input adds 1.0 = 1 << FRAC_BITS_DEF
  localparam int unsigned FRAC_BITS_DEF = 5;
  localparam int unsigned ONE = 32'd1 << FRAC_BITS_DEF;

  // Scheduler sweep states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_UPDATE = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  // Width that holds pot * lambda_num without overflow
  function automatic int unsigned prod_width(input int unsigned w, input int unsigned lambda_num);
    return w + $clog2(lambda_num + 1);
  endfunction

  // Raw value of an input weight of 1.0 for a given fractional width
  function automatic int unsigned one_of(input int unsigned frac_bits);
    return 32'd1 << frac_bits;
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF step: leak, integrate, saturate, threshold.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int unsigned W          = POT_W,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned LAMBDA_NUM = 8,
  parameter int unsigned LAMBDA_DEN = 10,
  parameter int unsigned THRESH     = 40,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic [W-1:0] pot_in_i,
  input  logic         in_bit_i,
  output logic [W-1:0] pot_out_o,
  output logic         spike_o
);

  localparam int unsigned PW = prod_width(W, LAMBDA_NUM);
  localparam int unsigned SW = W + 1;

  logic [PW-1:0] prod_c;
  logic [W-1:0]  leak_c;
  logic [SW-1:0] sum_c;
  logic [W-1:0]  sat_c;

  // Leak is truncating; with LAMBDA_NUM <= LAMBDA_DEN it always fits in W bits
  always_comb begin
    prod_c    = PW'(pot_in_i) * PW'(LAMBDA_NUM);
    leak_c    = W'(prod_c / PW'(LAMBDA_DEN));
    sum_c     = SW'(leak_c) + (in_bit_i ? SW'(one_of(FRAC_BITS)) : SW'(0));
    sat_c     = sum_c[W] ? {W{1'b1}} : sum_c[W-1:0];
    spike_o   = (sat_c >= W'(THRESH));
    pot_out_o = spike_o ? W'(RESET_VAL) : sat_c;
  end

endmodule

// File: rtl/lif_layer_scheduler.sv
// Sweeps N virtual LIF neurons through one shared update unit per timestep.
module lif_layer_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = POT_W,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned LAMBDA_NUM = 8,
  parameter int unsigned LAMBDA_DEN = 10,
  parameter int unsigned THRESH     = 40,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_spikes,
  input  logic         clear,
  output logic         busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [N-1:0]  bits_q;
  logic [N-1:0]  shadow_q;
  logic [N-1:0]  shadow_d;
  logic [N-1:0]  spikes_q;
  logic [W-1:0]  pot_q [N];

  logic [W-1:0]  upd_pot;
  logic          upd_spike;

  lif_update_unit #(
    .W          (W),
    .FRAC_BITS  (FRAC_BITS),
    .LAMBDA_NUM (LAMBDA_NUM),
    .LAMBDA_DEN (LAMBDA_DEN),
    .THRESH     (THRESH),
    .RESET_VAL  (RESET_VAL)
  ) u_update (
    .pot_in_i  (pot_q[idx_q]),
    .in_bit_i  (bits_q[idx_q]),
    .pot_out_o (upd_pot),
    .spike_o   (upd_spike)
  );

  // Shadow spike vector including the neuron being updated this cycle
  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[idx_q] = upd_spike;
  end

  // FSM, index counter, potential array and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      bits_q   <= '0;
      shadow_q <= '0;
      spikes_q <= '0;
      for (int i = 0; i < int'(N); i++) pot_q[i] <= W'(RESET_VAL);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q <= S_CLEAR;
          end else if (in_valid) begin
            bits_q   <= in_bits;
            idx_q    <= '0;
            shadow_q <= '0;
            state_q  <= S_UPDATE;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < int'(N); i++) pot_q[i] <= W'(RESET_VAL);
          state_q <= S_IDLE;
        end
        S_UPDATE: begin
          pot_q[idx_q] <= upd_pot;
          shadow_q     <= shadow_d;
          if (idx_q == IW'(N - 1)) begin
            spikes_q <= shadow_d;
            state_q  <= S_OUTPUT;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake and status decode; in_ready drops the same cycle clear is seen
  assign in_ready   = rst_n && (state_q == S_IDLE) && !clear;
  assign out_valid  = (state_q == S_OUTPUT);
  assign out_spikes = spikes_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed bench for lif_layer_scheduler: default instance plus a saturating instance.
module tb_lif_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_bits;
  logic       out_ready;
  logic       clear;

  logic       in_ready, out_valid, busy;
  logic [3:0] out_spikes;
  logic       s_in_ready, s_out_valid, s_busy;
  logic [3:0] s_out_spikes;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lif_layer_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_spikes (out_spikes),
    .clear      (clear),
    .busy       (busy)
  );

  lif_layer_scheduler #(.LAMBDA_NUM(10), .LAMBDA_DEN(10), .THRESH(255)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_bits    (in_bits),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_spikes (s_out_spikes),
    .clear      (clear),
    .busy       (s_busy)
  );

  typedef struct {
    logic [3:0] bits;
    logic [3:0] exp_spk;
    int         pidx;
    int         exp_pot;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int pot(input int i);
    return int'(dut.pot_q[i]);
  endfunction

  function automatic int spot(input int i);
    return int'(dut_sat.pot_q[i]);
  endfunction

  // Bounded wait for out_valid; lat counts negedges after the accept edge
  task automatic wait_out(output int lat, output logic [3:0] spk, output logic [3:0] sspk);
    lat = 0; spk = '0; sspk = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c; spk = out_spikes; sspk = s_out_spikes;
        break;
      end
    end
  endtask

  // One full timestep with out_ready=1; starts and ends 1ns after a posedge in IDLE
  task automatic run_step(input logic [3:0] bits, output int lat,
                          output logic [3:0] spk, output logic [3:0] sspk);
    in_valid = 1'b1;
    in_bits  = bits;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat, spk, sspk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int         lat;
    logic [3:0] spk, sspk;

    tbl[0] = '{4'b0001, 4'b0000, 0, 32};
    tbl[1] = '{4'b0001, 4'b0001, 0, 0};
    tbl[2] = '{4'b0010, 4'b0000, 1, 32};
    tbl[3] = '{4'b0000, 4'b0000, 1, 25};
    tbl[4] = '{4'b0000, 4'b0000, 1, 20};
    tbl[5] = '{4'b0000, 4'b0000, 1, 16};
    tbl[6] = '{4'b0000, 4'b0000, 1, 12};
    tbl[7] = '{4'b1111, 4'b0010, 1, 0};
    tbl[8] = '{4'b1101, 4'b1101, 3, 0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_bits = '0; clear = 1'b0; out_ready = 1'b1;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst in_ready", int'(in_ready), 0);
    check("rst out_spikes", int'(out_spikes), 0);
    for (int i = 0; i < 4; i++) check($sformatf("rst pot%0d", i), pot(i), 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", int'(in_ready), 1);

    // Basic integration, firing and leak decay
    for (int v = 0; v < 9; v++) begin
      run_step(tbl[v].bits, lat, spk, sspk);
      check($sformatf("vec%0d latency", v), lat, 5);
      check($sformatf("vec%0d spikes", v), int'(spk), int'(tbl[v].exp_spk));
      check($sformatf("vec%0d pot%0d", v, tbl[v].pidx), pot(tbl[v].pidx), tbl[v].exp_pot);
    end

    // Saturation with lossless leak and THRESH=255
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      run_step(4'b1111, lat, spk, sspk);
      check($sformatf("sat step%0d spikes", k), int'(sspk), (k == 8) ? 15 : 0);
      check($sformatf("sat step%0d pot0", k), spot(0), (k == 8) ? 0 : 32 * k);
      check($sformatf("sat step%0d pot3", k), spot(3), (k == 8) ? 0 : 32 * k);
    end

    // Backpressure in OUTPUT with the next vector already pending
    do_reset();
    run_step(4'b0001, lat, spk, sspk);
    check("bp pre pot0", pot(0), 32);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 4'b0001;
    @(posedge clk); #1;
    in_bits = 4'b1111;
    wait_out(lat, spk, sspk);
    check("bp latency", lat, 5);
    check("bp spikes", int'(spk), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp c%0d out_valid", c), int'(out_valid), 1);
      check($sformatf("bp c%0d out_spikes", c), int'(out_spikes), 1);
      check($sformatf("bp c%0d in_ready", c), int'(in_ready), 0);
      check($sformatf("bp c%0d busy", c), int'(busy), 1);
    end
    check("bp pot0 held", pot(0), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp last out_valid", int'(out_valid), 1);
    @(negedge clk);
    check("bp idle out_valid", int'(out_valid), 0);
    check("bp idle busy", int'(busy), 0);
    check("bp idle in_ready", int'(in_ready), 1);
    check("bp idle out_spikes kept", int'(out_spikes), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next busy", int'(busy), 1);
    check("bp next in_ready", int'(in_ready), 0);
    wait_out(lat, spk, sspk);
    check("bp next latency", lat, 5);
    check("bp next spikes", int'(spk), 0);
    @(posedge clk); #1;
    check("bp next pot2", pot(2), 32);

    // Clear beats a simultaneous in_valid in IDLE
    clear = 1'b1; in_valid = 1'b1; in_bits = 4'b0001;
    #1;
    check("clr in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr busy", int'(busy), 1);
    check("clr state in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) check($sformatf("clr pot%0d", i), pot(i), 0);
    check("clr back in_ready", int'(in_ready), 1);
    check("clr back busy", int'(busy), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // clear during UPDATE must not disturb the sweep
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_out(lat, spk, sspk);
    check("clr upd remaining latency", lat, 2);
    check("clr upd spikes", int'(spk), 0);
    check("clr upd pot0", pot(0), 32);
    @(posedge clk); #1;
    check("clr upd idle busy", int'(busy), 0);

    // Asynchronous reset in the middle of a sweep
    in_valid = 1'b1; in_bits = 4'b1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("ar pre pot1", pot(1), 32);
    check("ar pre busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("ar out_valid", int'(out_valid), 0);
    check("ar busy", int'(busy), 0);
    check("ar in_ready", int'(in_ready), 0);
    for (int i = 0; i < 4; i++) check($sformatf("ar pot%0d", i), pot(i), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_step(4'b0001, lat, spk, sspk);
    check("ar after latency", lat, 5);
    check("ar after spikes", int'(spk), 0);
    check("ar after pot0", pot(0), 32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
